// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_if: AXI-lite channel bundle shared by the IFU/LSU arbiter and the crossbar
interface axi_lite_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin merge of IFU (m0) and LSU (m1) onto one AXI-lite port, one transaction at a time
module axi_lite_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  state_t state, state_nxt;
  logic gnt, gnt_nxt, last_grant, last_grant_nxt, aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic req0, req1, ar_en, r_en, aw_en, w_en, b_en, aw_hs, w_hs;
  assign req0  = m0.arvalid | m0.awvalid;
  assign req1  = m1.arvalid | m1.awvalid;
  assign ar_en = state == RD_ADDR;
  assign r_en  = state == RD_DATA;
  assign aw_en = (state == WR_ADDR) & ~aw_done;
  assign w_en  = (state == WR_ADDR) & ~w_done;
  assign b_en  = state == WR_RESP;
  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid & s.wready;
  // gnt is registered, so these muxes only switch while the channel is gated off in IDLE
  assign s.arvalid = ar_en & (gnt ? m1.arvalid : m0.arvalid);
  assign s.araddr  = gnt ? m1.araddr : m0.araddr;
  assign s.arid    = gnt ? m1.arid : m0.arid;
  assign s.arlen   = gnt ? m1.arlen : m0.arlen;
  assign s.arsize  = gnt ? m1.arsize : m0.arsize;
  assign s.arburst = gnt ? m1.arburst : m0.arburst;
  assign s.rready  = r_en & (gnt ? m1.rready : m0.rready);
  assign s.awvalid = aw_en & (gnt ? m1.awvalid : m0.awvalid);
  assign s.awaddr  = gnt ? m1.awaddr : m0.awaddr;
  assign s.awid    = gnt ? m1.awid : m0.awid;
  assign s.awlen   = gnt ? m1.awlen : m0.awlen;
  assign s.awsize  = gnt ? m1.awsize : m0.awsize;
  assign s.awburst = gnt ? m1.awburst : m0.awburst;
  assign s.wvalid  = w_en & (gnt ? m1.wvalid : m0.wvalid);
  assign s.wdata   = gnt ? m1.wdata : m0.wdata;
  assign s.wstrb   = gnt ? m1.wstrb : m0.wstrb;
  assign s.bready  = b_en & (gnt ? m1.bready : m0.bready);
  assign m0.arready = ar_en & ~gnt & s.arready;
  assign m1.arready = ar_en & gnt & s.arready;
  assign m0.awready = aw_en & ~gnt & s.awready;
  assign m1.awready = aw_en & gnt & s.awready;
  assign m0.wready  = w_en & ~gnt & s.wready;
  assign m1.wready  = w_en & gnt & s.wready;
  assign m0.rvalid  = r_en & ~gnt & s.rvalid;
  assign m1.rvalid  = r_en & gnt & s.rvalid;
  assign m0.rdata   = (r_en & ~gnt) ? s.rdata : '0;
  assign m1.rdata   = (r_en & gnt) ? s.rdata : '0;
  assign m0.rresp   = (r_en & ~gnt) ? s.rresp : '0;
  assign m1.rresp   = (r_en & gnt) ? s.rresp : '0;
  assign m0.rlast   = r_en & ~gnt & s.rlast;
  assign m1.rlast   = r_en & gnt & s.rlast;
  assign m0.bvalid  = b_en & ~gnt & s.bvalid;
  assign m1.bvalid  = b_en & gnt & s.bvalid;
  assign m0.bresp   = (b_en & ~gnt) ? s.bresp : '0;
  assign m1.bresp   = (b_en & gnt) ? s.bresp : '0;
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_grant_nxt = last_grant;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    case (state)
      IDLE: begin
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (req0 | req1) begin
          gnt_nxt        = (req0 & req1) ? ~last_grant : req1;
          last_grant_nxt = gnt_nxt;
          state_nxt      = (gnt_nxt ? m1.arvalid : m0.arvalid) ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: state_nxt = (s.arvalid & s.arready) ? RD_DATA : RD_ADDR;
      RD_DATA: state_nxt = (s.rvalid & s.rready & s.rlast) ? IDLE : RD_DATA;
      WR_ADDR: begin
        aw_done_nxt = aw_done | aw_hs;
        w_done_nxt  = w_done | w_hs;
        state_nxt   = (aw_done_nxt & w_done_nxt) ? WR_RESP : WR_ADDR;
      end
      WR_RESP: state_nxt = (s.bvalid & s.bready) ? IDLE : WR_RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= RR_INIT;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_grant_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scenario checks of the two-master AXI-lite arbiter
module tb_axi_lite_arbiter;
  logic clk, rst;
  int n = 0, nf = 0;
  axi_lite_if m0_if();
  axi_lite_if m1_if();
  axi_lite_if s_if();
  axi_lite_arbiter #(.RR_INIT(1'b1)) dut (.clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0; m0_if.arsize = 0; m0_if.arburst = 0; m0_if.rready = 0;
    m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awid = 0; m0_if.awlen = 0; m0_if.awsize = 0; m0_if.awburst = 0;
    m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arid = 0; m1_if.arlen = 0; m1_if.arsize = 0; m1_if.arburst = 0; m1_if.rready = 0;
    m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awid = 0; m1_if.awlen = 0; m1_if.awsize = 0; m1_if.awburst = 0;
    m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.bready = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0; s_if.rlast = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0;
  endtask
  task automatic apply_reset;
    rst = 1;
    clear;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    clear;
    m0_if.arvalid = 1; m1_if.awvalid = 1; m1_if.wvalid = 1;
    s_if.arready = 1; s_if.rvalid = 1; s_if.rdata = 32'hFFFF_FFFF; s_if.rresp = 2'b11; s_if.bvalid = 1; s_if.bresp = 2'b11;
    tick;
    n++; if (s_if.arvalid !== 1'b0) begin nf++; $display("FAIL rst_s_arvalid got %b want 0", s_if.arvalid); end
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL rst_s_awvalid got %b want 0", s_if.awvalid); end
    n++; if (m0_if.arready !== 1'b0) begin nf++; $display("FAIL rst_m0_arready got %b want 0", m0_if.arready); end
    n++; if (m0_if.rvalid !== 1'b0) begin nf++; $display("FAIL rst_m0_rvalid got %b want 0", m0_if.rvalid); end
    n++; if (m0_if.rdata !== 32'h0) begin nf++; $display("FAIL rst_m0_rdata got %h want 0", m0_if.rdata); end
    n++; if (m1_if.bvalid !== 1'b0) begin nf++; $display("FAIL rst_m1_bvalid got %b want 0", m1_if.bvalid); end
    n++; if (m1_if.bresp !== 2'b00) begin nf++; $display("FAIL rst_m1_bresp got %b want 0", m1_if.bresp); end
    n++; if (m0_if.rresp !== 2'b00) begin nf++; $display("FAIL rst_m0_rresp got %b want 0", m0_if.rresp); end
    clear;
    rst = 0;
  endtask
  task automatic test_read;
    apply_reset;
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000; m0_if.arid = 4'h3; m0_if.rready = 1;
    #1;
    n++; if (s_if.arvalid !== 1'b0) begin nf++; $display("FAIL rd_idle_arvalid got %b want 0", s_if.arvalid); end
    tick;
    #1;
    n++; if (s_if.arvalid !== 1'b1) begin nf++; $display("FAIL rd_arvalid got %b want 1", s_if.arvalid); end
    n++; if (s_if.araddr !== 32'h8000_0000) begin nf++; $display("FAIL rd_araddr got %h want 80000000", s_if.araddr); end
    n++; if (s_if.arid !== 4'h3) begin nf++; $display("FAIL rd_arid got %h want 3", s_if.arid); end
    n++; if (m0_if.arready !== 1'b0) begin nf++; $display("FAIL rd_m0_arready_early got %b want 0", m0_if.arready); end
    tick;
    s_if.arready = 1;
    #1;
    n++; if (m0_if.arready !== 1'b1) begin nf++; $display("FAIL rd_m0_arready got %b want 1", m0_if.arready); end
    n++; if (m1_if.arready !== 1'b0) begin nf++; $display("FAIL rd_m1_arready got %b want 0", m1_if.arready); end
    tick;
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rdata = 32'hDEAD_BEEF; s_if.rresp = 2'b00; s_if.rlast = 1;
    #1;
    n++; if (m0_if.rvalid !== 1'b1) begin nf++; $display("FAIL rd_m0_rvalid got %b want 1", m0_if.rvalid); end
    n++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin nf++; $display("FAIL rd_m0_rdata got %h want deadbeef", m0_if.rdata); end
    n++; if (m0_if.rresp !== 2'b00) begin nf++; $display("FAIL rd_m0_rresp got %b want 00", m0_if.rresp); end
    n++; if (m0_if.rlast !== 1'b1) begin nf++; $display("FAIL rd_m0_rlast got %b want 1", m0_if.rlast); end
    n++; if (s_if.rready !== 1'b1) begin nf++; $display("FAIL rd_s_rready got %b want 1", s_if.rready); end
    n++; if (m1_if.rvalid !== 1'b0) begin nf++; $display("FAIL rd_m1_rvalid got %b want 0", m1_if.rvalid); end
    n++; if (m1_if.rdata !== 32'h0) begin nf++; $display("FAIL rd_m1_rdata got %h want 0", m1_if.rdata); end
    tick;
    #1;
    n++; if (m0_if.rvalid !== 1'b0) begin nf++; $display("FAIL rd_after_m0_rvalid got %b want 0", m0_if.rvalid); end
    n++; if (s_if.rready !== 1'b0) begin nf++; $display("FAIL rd_after_s_rready got %b want 0", s_if.rready); end
    clear;
  endtask
  task automatic test_fairness;
    logic exp_ar, exp_r0, exp_r1;
    logic [31:0] exp_addr;
    apply_reset;
    m0_if.arvalid = 1; m0_if.araddr = 32'h100; m0_if.rready = 1;
    m1_if.arvalid = 1; m1_if.araddr = 32'h200; m1_if.rready = 1;
    s_if.arready = 1; s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'hA5;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_ar   = (c % 3) == 1;
      exp_addr = ((c / 3) % 2 == 0) ? 32'h100 : 32'h200;
      exp_r0   = ((c % 3) == 2) && ((c / 3) % 2 == 0);
      exp_r1   = ((c % 3) == 2) && ((c / 3) % 2 == 1);
      n++; if (s_if.arvalid !== exp_ar) begin nf++; $display("FAIL rr_arvalid c=%0d got %b want %b", c, s_if.arvalid, exp_ar); end
      if (exp_ar) begin
        n++; if (s_if.araddr !== exp_addr) begin nf++; $display("FAIL rr_araddr c=%0d got %h want %h", c, s_if.araddr, exp_addr); end
      end
      n++; if (m0_if.rvalid !== exp_r0) begin nf++; $display("FAIL rr_m0_rvalid c=%0d got %b want %b", c, m0_if.rvalid, exp_r0); end
      n++; if (m1_if.rvalid !== exp_r1) begin nf++; $display("FAIL rr_m1_rvalid c=%0d got %b want %b", c, m1_if.rvalid, exp_r1); end
      tick;
    end
    clear;
  endtask
  task automatic test_write_aw_first;
    apply_reset;
    m1_if.awvalid = 1; m1_if.awaddr = 32'h0200_4000; m1_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    #1;
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL wr_idle_awvalid got %b want 0", s_if.awvalid); end
    tick;
    #1;
    n++; if (s_if.awvalid !== 1'b1) begin nf++; $display("FAIL wr_awvalid got %b want 1", s_if.awvalid); end
    n++; if (s_if.awaddr !== 32'h0200_4000) begin nf++; $display("FAIL wr_awaddr got %h want 02004000", s_if.awaddr); end
    n++; if (m1_if.awready !== 1'b1) begin nf++; $display("FAIL wr_m1_awready got %b want 1", m1_if.awready); end
    n++; if (m0_if.awready !== 1'b0) begin nf++; $display("FAIL wr_m0_awready got %b want 0", m0_if.awready); end
    tick;
    m1_if.awvalid = 0;
    #1;
    n++; if (s_if.wvalid !== 1'b0) begin nf++; $display("FAIL wr_wait_wvalid got %b want 0", s_if.wvalid); end
    tick;
    #1;
    n++; if (s_if.bready !== 1'b0) begin nf++; $display("FAIL wr_early_bready got %b want 0", s_if.bready); end
    tick;
    m1_if.wvalid = 1; m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'hF;
    #1;
    n++; if (s_if.wvalid !== 1'b1) begin nf++; $display("FAIL wr_wvalid got %b want 1", s_if.wvalid); end
    n++; if (s_if.wdata !== 32'h1234_5678) begin nf++; $display("FAIL wr_wdata got %h want 12345678", s_if.wdata); end
    n++; if (s_if.wstrb !== 4'hF) begin nf++; $display("FAIL wr_wstrb got %h want f", s_if.wstrb); end
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL wr_dup_awvalid got %b want 0", s_if.awvalid); end
    n++; if (m1_if.wready !== 1'b1) begin nf++; $display("FAIL wr_m1_wready got %b want 1", m1_if.wready); end
    tick;
    m1_if.wvalid = 0; s_if.bvalid = 1; s_if.bresp = 2'b00;
    #1;
    n++; if (m1_if.bvalid !== 1'b1) begin nf++; $display("FAIL wr_m1_bvalid got %b want 1", m1_if.bvalid); end
    n++; if (m1_if.bresp !== 2'b00) begin nf++; $display("FAIL wr_m1_bresp got %b want 00", m1_if.bresp); end
    n++; if (s_if.bready !== 1'b1) begin nf++; $display("FAIL wr_s_bready got %b want 1", s_if.bready); end
    n++; if (m0_if.bvalid !== 1'b0) begin nf++; $display("FAIL wr_m0_bvalid got %b want 0", m0_if.bvalid); end
    tick;
    #1;
    n++; if (m1_if.bvalid !== 1'b0) begin nf++; $display("FAIL wr_after_m1_bvalid got %b want 0", m1_if.bvalid); end
    clear;
  endtask
  task automatic test_write_w_first;
    apply_reset;
    m1_if.awvalid = 1; m1_if.awaddr = 32'h44; m1_if.wvalid = 1; m1_if.wdata = 32'h99; m1_if.wstrb = 4'h3; m1_if.bready = 1;
    s_if.wready = 1;
    tick;
    #1;
    n++; if (s_if.wvalid !== 1'b1) begin nf++; $display("FAIL wf_wvalid got %b want 1", s_if.wvalid); end
    n++; if (m1_if.awready !== 1'b0) begin nf++; $display("FAIL wf_awready got %b want 0", m1_if.awready); end
    tick;
    s_if.awready = 1;
    #1;
    n++; if (s_if.wvalid !== 1'b0) begin nf++; $display("FAIL wf_dup_wvalid got %b want 0", s_if.wvalid); end
    n++; if (m1_if.wready !== 1'b0) begin nf++; $display("FAIL wf_dup_wready got %b want 0", m1_if.wready); end
    n++; if (s_if.awvalid !== 1'b1) begin nf++; $display("FAIL wf_awvalid got %b want 1", s_if.awvalid); end
    n++; if (m1_if.awready !== 1'b1) begin nf++; $display("FAIL wf_m1_awready got %b want 1", m1_if.awready); end
    tick;
    s_if.bvalid = 1; s_if.bresp = 2'b10;
    #1;
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL wf_resp_awvalid got %b want 0", s_if.awvalid); end
    n++; if (s_if.wvalid !== 1'b0) begin nf++; $display("FAIL wf_resp_wvalid got %b want 0", s_if.wvalid); end
    n++; if (m1_if.bvalid !== 1'b1) begin nf++; $display("FAIL wf_m1_bvalid got %b want 1", m1_if.bvalid); end
    n++; if (m1_if.bresp !== 2'b10) begin nf++; $display("FAIL wf_m1_bresp got %b want 10", m1_if.bresp); end
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    tick;
    #1;
    n++; if (m1_if.bvalid !== 1'b0) begin nf++; $display("FAIL wf_single_b got %b want 0", m1_if.bvalid); end
    clear;
  endtask
  task automatic test_write_same_cycle;
    apply_reset;
    m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.wdata = 32'h77; m1_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    tick;
    #1;
    n++; if (s_if.awvalid !== 1'b1 || s_if.wvalid !== 1'b1) begin nf++; $display("FAIL sc_valids got %b%b want 11", s_if.awvalid, s_if.wvalid); end
    tick;
    #1;
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL sc_dup_awvalid got %b want 0", s_if.awvalid); end
    n++; if (s_if.wvalid !== 1'b0) begin nf++; $display("FAIL sc_dup_wvalid got %b want 0", s_if.wvalid); end
    n++; if (s_if.bready !== 1'b1) begin nf++; $display("FAIL sc_bready got %b want 1", s_if.bready); end
    tick;
    s_if.bvalid = 1;
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    #1;
    n++; if (m1_if.bvalid !== 1'b1) begin nf++; $display("FAIL sc_m1_bvalid got %b want 1", m1_if.bvalid); end
    tick;
    #1;
    n++; if (m1_if.bvalid !== 1'b0) begin nf++; $display("FAIL sc_single_b got %b want 0", m1_if.bvalid); end
    clear;
  endtask
  task automatic test_read_before_write;
    apply_reset;
    m1_if.arvalid = 1; m1_if.araddr = 32'h300; m1_if.rready = 1;
    m1_if.awvalid = 1; m1_if.awaddr = 32'h400; m1_if.wvalid = 1; m1_if.bready = 1;
    s_if.arready = 1; s_if.rvalid = 1; s_if.rlast = 1; s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1;
    tick;
    #1;
    n++; if (s_if.arvalid !== 1'b1) begin nf++; $display("FAIL rw_arvalid got %b want 1", s_if.arvalid); end
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL rw_early_awvalid got %b want 0", s_if.awvalid); end
    tick;
    m1_if.arvalid = 0;
    #1;
    n++; if (m1_if.rvalid !== 1'b1) begin nf++; $display("FAIL rw_m1_rvalid got %b want 1", m1_if.rvalid); end
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL rw_rd_awvalid got %b want 0", s_if.awvalid); end
    tick;
    #1;
    n++; if (s_if.awvalid !== 1'b0) begin nf++; $display("FAIL rw_idle_awvalid got %b want 0", s_if.awvalid); end
    tick;
    #1;
    n++; if (s_if.awvalid !== 1'b1) begin nf++; $display("FAIL rw_awvalid got %b want 1", s_if.awvalid); end
    n++; if (s_if.awaddr !== 32'h400) begin nf++; $display("FAIL rw_awaddr got %h want 400", s_if.awaddr); end
    tick;
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    #1;
    n++; if (m1_if.bvalid !== 1'b1) begin nf++; $display("FAIL rw_m1_bvalid got %b want 1", m1_if.bvalid); end
    tick;
    clear;
  endtask
  task automatic test_reset_mid;
    apply_reset;
    m0_if.arvalid = 1; m0_if.araddr = 32'h100; m0_if.rready = 1;
    s_if.arready = 1;
    tick;
    tick;
    s_if.rvalid = 1; s_if.rdata = 32'h5555_5555; s_if.rlast = 0;
    #1;
    n++; if (m0_if.rvalid !== 1'b1) begin nf++; $display("FAIL mid_pre_rvalid got %b want 1", m0_if.rvalid); end
    #2;
    rst = 1;
    #1;
    n++; if (m0_if.rvalid !== 1'b0) begin nf++; $display("FAIL mid_rvalid got %b want 0", m0_if.rvalid); end
    n++; if (m0_if.rdata !== 32'h0) begin nf++; $display("FAIL mid_rdata got %h want 0", m0_if.rdata); end
    n++; if (s_if.rready !== 1'b0) begin nf++; $display("FAIL mid_rready got %b want 0", s_if.rready); end
    n++; if (s_if.arvalid !== 1'b0) begin nf++; $display("FAIL mid_arvalid got %b want 0", s_if.arvalid); end
    s_if.rvalid = 0;
    m1_if.arvalid = 1; m1_if.araddr = 32'h200;
    tick;
    rst = 0;
    #1;
    n++; if (s_if.arvalid !== 1'b0) begin nf++; $display("FAIL mid_idle_arvalid got %b want 0", s_if.arvalid); end
    tick;
    #1;
    n++; if (s_if.araddr !== 32'h100) begin nf++; $display("FAIL mid_tie_araddr got %h want 100", s_if.araddr); end
    n++; if (m0_if.arready !== 1'b1) begin nf++; $display("FAIL mid_tie_m0_arready got %b want 1", m0_if.arready); end
    n++; if (m1_if.arready !== 1'b0) begin nf++; $display("FAIL mid_tie_m1_arready got %b want 0", m1_if.arready); end
    clear;
  endtask
  initial begin
    rst = 1;
    clear;
    test_reset;
    test_read;
    test_fairness;
    test_write_aw_first;
    test_write_w_first;
    test_write_same_cycle;
    test_read_before_write;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter. This is the converging counterpart of the address-decoding crossbar.
- Merges IFU (m0) and LSU (m1) requests onto one upstream axi_lite_if. That interface feeds the crossbar.
- Serializes transactions, one outstanding at a time, using round-robin grant.
- Grant is locked from address phase until the response handshake completes.

Parameters:
- RR_INIT, 1'b1: value of last_grant after reset. 1 means m0 wins the first tie.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- m0  axi_lite_if.slave  intf  IFU-side master port; read channels used, write channels tied off by IFU
- m1  axi_lite_if.slave  intf  LSU-side master port; read and write
- s  axi_lite_if.master  intf  downstream port toward crossbar

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, gnt=0, last_grant=RR_INIT, aw_done=0, w_done=0.
  - All valid/ready outputs on m0, m1 and s are 0 while rst is high and in IDLE.
  - rdata, rresp and bresp toward the masters are 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- Request definition: req_i = mi.arvalid | mi.awvalid.
- IDLE:
  - If only one req_i is set, latch gnt=i.
  - If both are set, gnt = ~last_grant.
  - Set last_grant=gnt in the same edge.
  - Within the granted master, arvalid beats awvalid: go to RD_ADDR if arvalid, else WR_ADDR.
  - Clear aw_done and w_done.
  - No forwarding happens in IDLE, so grant latency is 1 cycle.
- RD_ADDR:
  - Forward m[gnt].arvalid to s.arvalid, and s.arready back to m[gnt].arready.
  - On arvalid&arready, go to RD_DATA.
- RD_DATA:
  - Forward s.rvalid, rdata, rresp, rlast to m[gnt], and m[gnt].rready to s.rready.
  - On rvalid&rready&rlast, go to IDLE.
  - If rlast is unused, it is tied 1 at the source.
- WR_ADDR:
  - Forward aw and w channels independently, each gated by its own done flag.
  - s.awvalid = m.awvalid & ~aw_done; s.wvalid = m.wvalid & ~w_done. Same gating applies to the readies back.
  - Set aw_done on the AW handshake and w_done on the W handshake.
  - Go to WR_RESP when both are done, or both complete in the same cycle.
- WR_RESP:
  - Forward bvalid and bresp to m[gnt], and bready to s.
  - On bvalid&bready, go to IDLE.
- Non-granted master: arready, awready, wready, rvalid and bvalid are held 0 in every state. Its requests wait and are not dropped.
- Address/data/attribute fields pass through combinationally from m[gnt]: araddr, arid, arlen, arsize, arburst, aw*, wdata, wstrb. gnt is a register, so the mux select is glitch-free.
- Response codes pass through unmodified. The arbiter generates no errors.
- Minimum gap of one IDLE cycle between back-to-back transactions.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, and so on.
- Simultaneous events:
  - A master asserting both arvalid and awvalid gets the read first. Its write is arbitrated again in the next IDLE, against the other master.
- Reset mid-transaction: immediate return to IDLE with outputs 0. No completion is issued to either master, and the downstream transfer is abandoned (whole system resets together).
- A master must not drop a valid before its handshake (AXI rule). Behaviour is undefined otherwise.

Test Plan:
1. m0 reads 0x8000_0000, slave arready at 2nd cycle, rdata=0xDEADBEEF -> s.araddr=0x8000_0000. m0 receives rdata 0xDEADBEEF, rresp=0. m1 sees no ready/valid throughout.
2. m0 and m1 assert arvalid on the same cycle, held continuously for 4 transactions -> grant order m0, m1, m0, m1. Exactly one IDLE cycle between them.
3. m1 writes 0x0200_4000 with data 0x1234_5678, wstrb=0xF. awvalid precedes wvalid by 3 cycles -> aw forwarded once, then w. WR_RESP is entered only after both. bresp=0 is returned to m1.
4. m1 write where W handshake precedes AW, and a variant where both complete the same cycle -> no duplicate awvalid/wvalid on s after the done flags are set. Single B returned.
5. m1 asserts arvalid and awvalid together, m0 idle -> read completes first, then the write is granted in the following arbitration.
6. rst asserted during RD_DATA with s.rvalid=1 -> outputs 0 asynchronously, state IDLE. After release, m0 wins the tie against m1 (RR_INIT=1).
